// File: rtl/rs485_pkg.sv
// rs485_pkg: shared constants, state enums and the frame-bit helper for the
// RS485 poll scheduler and its receiver.
package rs485_pkg;
  localparam int         FRAME_BITS    = 11;  // start + 8 data + 2 stop
  localparam int         DATA_BITS     = 8;
  localparam logic [7:0] NACK_BYTE_DEF = 8'hEE;

  typedef enum logic [1:0] {IDLE, TURN, SEND, DONE} sched_state_t;
  typedef enum logic [1:0] {HUNT, DATA, STOP}       rx_state_t;

  // Line level of bit idx (0..10) of an 11-bit frame carrying b, LSB first.
  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
    if (idx == 4'd0)      return 1'b0;
    else if (idx <= 4'd8) return b[3'(idx - 4'd1)];
    else                  return 1'b1;
  endfunction
endpackage

// File: rtl/rs485_rx_frame.sv
// rs485_rx_frame: 1-bit-per-clk UART-style byte receiver.
//   clk, rst (sync, active low), rx (idle high), enable (low forces HUNT)
//   rx_byte     last assembled byte
//   byte_valid  1-cycle pulse in the stop-sample cycle when stop bit is 1
//   frame_err   1-cycle pulse in the stop-sample cycle when stop bit is 0
module rs485_rx_frame
  import rs485_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       enable,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);
  rx_state_t  r_state;
  logic [2:0] r_cnt;
  logic [7:0] r_sh;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= HUNT;
      r_cnt   <= '0;
      r_sh    <= '0;
    end else if (!enable) begin
      // Our own transmission is on the line; drop any partial frame.
      r_state <= HUNT;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        HUNT: if (!rx) begin
          r_state <= DATA;
          r_cnt   <= '0;
        end
        DATA: begin
          r_sh  <= {rx, r_sh[7:1]};
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'(DATA_BITS - 1)) r_state <= STOP;
        end
        // Second stop bit is left to HUNT, which simply idles on a 1.
        default: r_state <= HUNT;
      endcase
    end
  end

  assign rx_byte    = r_sh;
  assign byte_valid = enable && (r_state == STOP) &&  rx;
  assign frame_err  = enable && (r_state == STOP) && !rx;
endmodule

// File: rtl/rs485_poll_scheduler.sv
// rs485_poll_scheduler: RS485 slave-side poll responder.
// A poll byte POLL_BASE+k snapshots slot k; after TURN_CYC cycles the driver
// is enabled and the word is sent MSB byte first (or NACK_BYTE if the slot
// was not valid), 11-bit frames back to back, 1 bit per clk.
// Ports:
//   clk, rst (sync, active low), rx (serial in, idle high)
//   src_data [NUM_SRC*16]  packed slot words, src_valid [NUM_SRC]
//   src_ack  [NUM_SRC]     1-cycle pulse when a valid slot word is taken
//   tx, tx_en              serial out and driver enable
//   busy                   response pending or in progress
//   poll_drop              1-cycle pulse when an in-range poll is discarded
// Build option: define RS485_SCHED_CHKSUM_EN to append MSB^LSB as a third
// byte to valid-data responses.
module rs485_poll_scheduler
  import rs485_pkg::*;
#(
  parameter int         NUM_SRC   = 4,
  parameter logic [7:0] POLL_BASE = 8'h01,
  parameter int         TURN_CYC  = 2,
  parameter logic [7:0] NACK_BYTE = NACK_BYTE_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  input  logic [NUM_SRC*16-1:0]  src_data,
  input  logic [NUM_SRC-1:0]     src_valid,
  output logic [NUM_SRC-1:0]     src_ack,
  output logic                   tx,
  output logic                   tx_en,
  output logic                   busy,
  output logic                   poll_drop
);
  localparam int SLOT_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
`ifdef RS485_SCHED_CHKSUM_EN
  localparam logic [1:0] NB_DATA = 2'd3;
`else
  localparam logic [1:0] NB_DATA = 2'd2;
`endif

  logic [7:0]        w_byte;
  logic              w_byte_valid, w_frame_err;
  logic [8:0]        w_off;
  logic              w_hit;
  logic [SLOT_W-1:0] w_slot;
  logic [15:0]       w_sel_word;
  logic              w_sel_valid;
  logic [7:0]        w_cur_byte;

  sched_state_t      r_state;
  logic [15:0]       r_word;
  logic              r_v;
  logic [1:0]        r_nbytes, r_byte_cnt;
  logic [3:0]        r_bit_cnt;
  logic [7:0]        r_turn_cnt;
  logic              r_tx, r_tx_en, r_busy, r_drop;
  logic [NUM_SRC-1:0] r_ack;

  rs485_rx_frame u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .enable     (!r_tx_en),
    .rx_byte    (w_byte),
    .byte_valid (w_byte_valid),
    .frame_err  (w_frame_err)
  );

  // 9-bit subtraction: bytes below POLL_BASE wrap to >= 256 and miss.
  assign w_off       = {1'b0, w_byte} - {1'b0, POLL_BASE};
  assign w_hit       = w_byte_valid && (w_off < 9'(NUM_SRC));
  assign w_slot      = w_off[SLOT_W-1:0];
  assign w_sel_word  = src_data[16*w_slot +: 16];
  assign w_sel_valid = src_valid[w_slot];

  always_comb begin
    w_cur_byte = NACK_BYTE;
    if (r_v) begin
      case (r_byte_cnt)
        2'd0:    w_cur_byte = r_word[15:8];
`ifdef RS485_SCHED_CHKSUM_EN
        2'd1:    w_cur_byte = r_word[7:0];
        default: w_cur_byte = r_word[15:8] ^ r_word[7:0];
`else
        default: w_cur_byte = r_word[7:0];
`endif
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_word     <= '0;
      r_v        <= 1'b0;
      r_nbytes   <= '0;
      r_byte_cnt <= '0;
      r_bit_cnt  <= '0;
      r_turn_cnt <= '0;
      r_tx       <= 1'b1;
      r_tx_en    <= 1'b0;
      r_busy     <= 1'b0;
      r_ack      <= '0;
      r_drop     <= 1'b0;
    end else begin
      r_ack  <= '0;
      r_drop <= 1'b0;
      case (r_state)
        IDLE: if (w_hit) begin
          r_word     <= w_sel_word;
          r_v        <= w_sel_valid;
          r_nbytes   <= w_sel_valid ? NB_DATA : 2'd1;
          if (w_sel_valid) r_ack <= NUM_SRC'(1) << w_slot;
          r_busy     <= 1'b1;
          r_turn_cnt <= '0;
          r_state    <= TURN;
        end
        TURN: begin
          if (w_hit) r_drop <= 1'b1;
          if (r_turn_cnt == 8'(TURN_CYC - 1)) begin
            r_state    <= SEND;
            r_tx_en    <= 1'b1;
            r_tx       <= 1'b0;  // start bit of byte 0
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
          end else begin
            r_turn_cnt <= r_turn_cnt + 8'd1;
          end
        end
        SEND: begin
          if (r_bit_cnt == 4'(FRAME_BITS - 1)) begin
            if (r_byte_cnt == r_nbytes - 2'd1) begin
              r_state <= DONE;
              r_tx_en <= 1'b0;
              r_tx    <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_byte_cnt <= r_byte_cnt + 2'd1;
              r_bit_cnt  <= '0;
              r_tx       <= 1'b0;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
            r_tx      <= frame_bit(w_cur_byte, r_bit_cnt + 4'd1);
          end
        end
        default: begin  // DONE
          if (w_hit) r_drop <= 1'b1;
          r_tx_en <= 1'b0;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign src_ack   = r_ack;
  assign tx        = r_tx;
  assign tx_en     = r_tx_en;
  assign busy      = r_busy;
  assign poll_drop = r_drop;
endmodule

// File: tb/tb_rs485_poll_scheduler.sv
module tb_rs485_poll_scheduler;
  localparam int         NS   = 4;
  localparam logic [7:0] PB   = 8'h01;
  localparam int         TA   = 2;
  localparam int         TBT  = 20;
  localparam logic [7:0] NACK = 8'hEE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rx_drv;
  int   sel;
  logic [NS*16-1:0] src_data;
  logic [NS-1:0]    src_valid;

  logic rx_a, tx_a, en_a, busy_a, drop_a;
  logic rx_b, tx_b, en_b, busy_b, drop_b;
  logic [NS-1:0] ack_a, ack_b;
  logic tx_o, en_o, busy_o, drop_o;
  logic [NS-1:0] ack_o;

  assign rx_a   = (sel == 0) ? rx_drv : 1'b1;
  assign rx_b   = (sel == 1) ? rx_drv : 1'b1;
  assign tx_o   = (sel == 0) ? tx_a   : tx_b;
  assign en_o   = (sel == 0) ? en_a   : en_b;
  assign busy_o = (sel == 0) ? busy_a : busy_b;
  assign drop_o = (sel == 0) ? drop_a : drop_b;
  assign ack_o  = (sel == 0) ? ack_a  : ack_b;

  rs485_poll_scheduler #(.NUM_SRC(NS), .POLL_BASE(PB), .TURN_CYC(TA), .NACK_BYTE(NACK)) dut (
    .clk(clk), .rst(rst), .rx(rx_a), .src_data(src_data), .src_valid(src_valid),
    .src_ack(ack_a), .tx(tx_a), .tx_en(en_a), .busy(busy_a), .poll_drop(drop_a));

  rs485_poll_scheduler #(.NUM_SRC(NS), .POLL_BASE(PB), .TURN_CYC(TBT), .NACK_BYTE(NACK)) dut_t20 (
    .clk(clk), .rst(rst), .rx(rx_b), .src_data(src_data), .src_valid(src_valid),
    .src_ack(ack_b), .tx(tx_b), .tx_en(en_b), .busy(busy_b), .poll_drop(drop_b));

  bit         rxq[$];
  logic [7:0] resp[$];
  int n_pass = 0, n_tot = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] b, input bit stop_ok);
    rxq.push_back(1'b0);
    for (int j = 0; j < 8; j++) rxq.push_back(b[j]);
    rxq.push_back(stop_ok);
    rxq.push_back(1'b1);
  endtask

  // Reference: what a slave must answer to poll p given the current sources.
  task automatic model(input logic [7:0] p, output bit hit, output int ack_slot);
    int off;
    logic [7:0] msb, lsb;
    resp.delete();
    off = int'(p) - int'(PB);
    hit = (off >= 0 && off < NS);
    ack_slot = -1;
    if (hit) begin
      if (src_valid[off]) begin
        msb = src_data[16*off+8 +: 8];
        lsb = src_data[16*off +: 8];
        resp.push_back(msb);
        resp.push_back(lsb);
`ifdef RS485_SCHED_CHKSUM_EN
        resp.push_back(msb ^ lsb);
`endif
        ack_slot = off;
      end else begin
        resp.push_back(NACK);
      end
    end
  endtask

  // Drive rxq bit-per-cycle and compare every cycle. c_idx: sample index of
  // the capture edge (-1: none); rst_i: cycle where reset is pulled low.
  task automatic run(input string name, input int turn, input int c_idx, input int ack_slot,
                     input int drop_idx, input int rst_i, input int ncyc);
    logic e_tx, e_en, e_busy, e_drop;
    logic [NS-1:0] e_ack;
    logic [7:0] bb;
    int k, j, nb;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      rx_drv = (i < rxq.size()) ? rxq[i] : 1'b1;
      if (i == rst_i) rst = 1'b0;
      if (rst_i >= 0 && i == rst_i + 2) rst = 1'b1;
      if (c_idx >= 0 && i == c_idx + 1) begin
        src_data  = {$urandom, $urandom};
        src_valid = NS'($urandom);
      end
      @(posedge clk);
      #1;
      e_tx = 1'b1; e_en = 1'b0; e_busy = 1'b0; e_ack = '0;
      e_drop = (i == drop_idx);
      k = i - c_idx;
      nb = resp.size();
      if (!(rst_i >= 0 && i >= rst_i) && c_idx >= 0 && k >= 0) begin
        e_busy = (k < turn + 11*nb);
        if (k == 0 && ack_slot >= 0) e_ack = NS'(1) << ack_slot;
        if (k >= turn && k < turn + 11*nb) begin
          e_en = 1'b1;
          j  = (k - turn) % 11;
          bb = resp[(k - turn) / 11];
          e_tx = (j == 0) ? 1'b0 : (j <= 8) ? bb[j-1] : 1'b1;
        end
      end
      check($sformatf("%s tx@%0d", name, i),    tx_o,   e_tx);
      check($sformatf("%s tx_en@%0d", name, i), en_o,   e_en);
      check($sformatf("%s busy@%0d", name, i),  busy_o, e_busy);
      check($sformatf("%s ack@%0d", name, i),   ack_o,  e_ack);
      check($sformatf("%s drop@%0d", name, i),  drop_o, e_drop);
    end
    rxq.delete();
  endtask

  task automatic poll_case(input string name, input int s, input logic [7:0] p);
    bit hit;
    int ack_slot, turn;
    model(p, hit, ack_slot);
    push_frame(p, 1'b1);
    sel  = s;
    turn = s ? TBT : TA;
    run(name, turn, hit ? 9 : -1, ack_slot, -1, -1, hit ? 9 + turn + 11*resp.size() + 4 : 30);
  endtask

  initial begin
    bit hit;
    int ack_slot;
    logic [7:0] p;
    rst = 1'b0; rx_drv = 1'b1; sel = 0; src_data = '0; src_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst tx_a", tx_a, 1'b1);     check("rst tx_en_a", en_a, 1'b0);
    check("rst busy_a", busy_a, 1'b0); check("rst ack_a", ack_a, '0);
    check("rst drop_a", drop_a, 1'b0); check("rst tx_b", tx_b, 1'b1);
    check("rst tx_en_b", en_b, 1'b0);  check("rst busy_b", busy_b, 1'b0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);

    // slot 0 valid 3FE0
    src_data = {16'h1111, 16'h2222, 16'h3333, 16'h3FE0};
    src_valid = 4'b0001;
    poll_case("slot0", 0, 8'h01);

    // slot 2 not valid -> NACK
    src_data = {$urandom, $urandom};
    src_valid = 4'b1011;
    poll_case("nack2", 0, 8'h03);

    // range boundaries
    poll_case("oor07", 0, 8'h07);
    poll_case("oor00", 0, 8'h00);
    poll_case("oor05", 0, 8'h05);
    src_valid = 4'b1000;
    poll_case("slot3", 0, 8'h04);

    // poll for slot 1 arrives during TURN of slot 0 response (TURN_CYC=20)
    src_data = {$urandom, $urandom};
    src_valid = 4'b1111;
    model(8'h01, hit, ack_slot);
    push_frame(8'h01, 1'b1);
    push_frame(8'h02, 1'b1);
    sel = 1;
    run("drop", TBT, 9, ack_slot, 20, -1, 9 + TBT + 11*resp.size() + 4);

    // framing error then good poll
    src_valid = 4'b0001;
    model(8'h01, hit, ack_slot);
    push_frame(8'h01, 1'b0);
    push_frame(8'h01, 1'b1);
    sel = 0;
    run("ferr", TA, 20, ack_slot, -1, -1, 20 + TA + 11*resp.size() + 4);

    // reset during bit 4 of first response byte, then normal poll
    src_valid = 4'b0001;
    model(8'h01, hit, ack_slot);
    push_frame(8'h01, 1'b1);
    run("rstmid", TA, 9, ack_slot, -1, 9 + TA + 5, 40);
    src_valid = 4'b0001;
    poll_case("postrst", 0, 8'h01);

    // randomized polls on both instances
    for (int n = 0; n < 12; n++) begin
      src_data  = {$urandom, $urandom};
      src_valid = NS'($urandom);
      p = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      poll_case($sformatf("rnd%0d", n), (n % 4 == 3) ? 1 : 0, p);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
